// File: rtl/cache_fill_pkg.sv
// rtl/cache_fill_pkg.sv - shared types and default widths for the cache fill unit
// Purpose: default geometry of the fill unit, the queued request/response
//          payload layouts and a log2 helper for id widths.
// Ports:   none (package).
package cache_fill_pkg;

  localparam int CF_MSHR_SIZE       = 16;
  localparam int CF_LINE_ADDR_WIDTH = 26;
  localparam int CF_LINE_SIZE       = 64;
  localparam int LINE_WIDTH         = CF_LINE_SIZE * 8;
  localparam int CF_MSHR_ADDR_WIDTH = (CF_MSHR_SIZE > 1) ? $clog2(CF_MSHR_SIZE) : 1;

  // Miss waiting to be issued to memory; the MSHR id doubles as the memory tag.
  typedef struct packed {
    logic [CF_LINE_ADDR_WIDTH-1:0] addr;
    logic [CF_MSHR_ADDR_WIDTH-1:0] id;
  } miss_req_t;

  // Memory response waiting to be handed to the bank as a fill.
  typedef struct packed {
    logic [CF_MSHR_ADDR_WIDTH-1:0] id;
    logic [LINE_WIDTH-1:0]         data;
  } fill_rsp_t;

  function automatic int log2up(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cache_fill_unit_fill_fifo.sv
// rtl/cache_fill_unit_fill_fifo.sv - registered synchronous FIFO used for both fill-unit queues
// Purpose: DEPTH-entry FIFO whose head is read straight from storage registers,
//          so pop_data carries no combinational path from push_data.
// Ports:   clk, reset (sync, active-high)
//          push, push_data  - write side; ignored while full
//          pop,  pop_data   - read side; pop ignored while empty, pop_data = head
//          full, empty      - derived from the registered occupancy count
module fill_fifo #(
  parameter int DATAW = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [DATAW-1:0] push_data,
  input  logic             pop,
  output logic [DATAW-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DATAW-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Storage is not reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/cache_fill_unit.sv
// rtl/cache_fill_unit.sv - turns MSHR misses into memory reads and memory responses into bank fills
// Purpose: queues tagged miss requests toward memory, queues out-of-order memory
//          responses toward the bank, and tracks which MSHR ids have a read in flight.
//          Width parameters are expected to match the cache_fill_pkg defaults,
//          which size the queued payload structs.
// Optional: CACHE_FILL_PERF_EN adds perf_fills and perf_mem_stalls counters.
// Ports:   clk, reset (sync, active-high)
//          miss_valid/miss_ready/miss_id/miss_addr              - misses from the bank
//          mem_req_valid/mem_req_ready/mem_req_addr/mem_req_tag - line reads to memory
//          mem_rsp_valid/mem_rsp_ready/mem_rsp_tag/mem_rsp_data - read data from memory
//          fill_valid/fill_ready/fill_id/fill_data              - fills to the bank
//          pending - per-id outstanding read flags; idle - nothing queued or pending
//          perf_fills, perf_mem_stalls (CACHE_FILL_PERF_EN only)
module cache_fill_unit
  import cache_fill_pkg::*;
#(
  parameter int MSHR_SIZE       = CF_MSHR_SIZE,
  parameter int LINE_ADDR_WIDTH = CF_LINE_ADDR_WIDTH,
  parameter int LINE_SIZE       = CF_LINE_SIZE,
  parameter int REQ_QUEUE_DEPTH = 4,
  parameter int RSP_QUEUE_DEPTH = 2,
  parameter int MSHR_ADDR_WIDTH = log2up(MSHR_SIZE)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       miss_valid,
  input  logic [MSHR_ADDR_WIDTH-1:0] miss_id,
  input  logic [LINE_ADDR_WIDTH-1:0] miss_addr,
  output logic                       miss_ready,
  output logic                       mem_req_valid,
  output logic [LINE_ADDR_WIDTH-1:0] mem_req_addr,
  output logic [MSHR_ADDR_WIDTH-1:0] mem_req_tag,
  input  logic                       mem_req_ready,
  input  logic                       mem_rsp_valid,
  input  logic [MSHR_ADDR_WIDTH-1:0] mem_rsp_tag,
  input  logic [LINE_SIZE*8-1:0]     mem_rsp_data,
  output logic                       mem_rsp_ready,
  output logic                       fill_valid,
  output logic [MSHR_ADDR_WIDTH-1:0] fill_id,
  output logic [LINE_SIZE*8-1:0]     fill_data,
  input  logic                       fill_ready,
  output logic [MSHR_SIZE-1:0]       pending,
  output logic                       idle
`ifdef CACHE_FILL_PERF_EN
  ,
  output logic [31:0]                perf_fills,
  output logic [31:0]                perf_mem_stalls
`endif
);

  miss_req_t            req_push_data;
  miss_req_t            req_head;
  fill_rsp_t            rsp_push_data;
  fill_rsp_t            rsp_head;
  logic                 req_full;
  logic                 req_empty;
  logic                 rsp_full;
  logic                 rsp_empty;
  logic                 miss_fire;
  logic                 mem_req_fire;
  logic                 mem_rsp_fire;
  logic                 fill_fire;
  logic [MSHR_SIZE-1:0] set_mask;
  logic [MSHR_SIZE-1:0] clr_mask;

  // ---------------- request path ----------------
  assign miss_ready         = !req_full;
  assign miss_fire          = miss_valid && miss_ready;
  assign req_push_data.addr = miss_addr;
  assign req_push_data.id   = miss_id;

  fill_fifo #(
    .DATAW($bits(miss_req_t)),
    .DEPTH(REQ_QUEUE_DEPTH)
  ) u_req_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (miss_fire),
    .push_data(req_push_data),
    .pop      (mem_req_fire),
    .pop_data (req_head),
    .full     (req_full),
    .empty    (req_empty)
  );

  assign mem_req_valid = !req_empty;
  assign mem_req_addr  = req_head.addr;
  assign mem_req_tag   = req_head.id;
  assign mem_req_fire  = mem_req_valid && mem_req_ready;

  // ---------------- response path ----------------
  assign mem_rsp_ready      = !rsp_full;
  assign mem_rsp_fire       = mem_rsp_valid && mem_rsp_ready;
  assign rsp_push_data.id   = mem_rsp_tag;
  assign rsp_push_data.data = mem_rsp_data;

  fill_fifo #(
    .DATAW($bits(fill_rsp_t)),
    .DEPTH(RSP_QUEUE_DEPTH)
  ) u_rsp_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (mem_rsp_fire),
    .push_data(rsp_push_data),
    .pop      (fill_fire),
    .pop_data (rsp_head),
    .full     (rsp_full),
    .empty    (rsp_empty)
  );

  assign fill_valid = !rsp_empty;
  assign fill_id    = rsp_head.id;
  assign fill_data  = rsp_head.data;
  assign fill_fire  = fill_valid && fill_ready;

  // ---------------- outstanding-read tracking ----------------
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (miss_fire) begin
      set_mask[miss_id] = 1'b1;
    end
    if (fill_fire) begin
      clr_mask[fill_id] = 1'b1;
    end
  end

  // Set is applied after clear so a same-id re-allocation in the fill cycle survives.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending <= '0;
    end else begin
      pending <= (pending & ~clr_mask) | set_mask;
    end
  end

  assign idle = req_empty && rsp_empty && (pending == '0);

  // Protocol errors from the bank or memory are flagged but do not stall the flow.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (miss_fire) begin
        assert (!pending[miss_id])
          else $error("cache_fill_unit: miss on id %0d already pending", miss_id);
      end
      if (mem_rsp_fire) begin
        assert (pending[mem_rsp_tag])
          else $error("cache_fill_unit: response tag %0d not pending", mem_rsp_tag);
      end
    end
  end

`ifdef CACHE_FILL_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fills      <= '0;
      perf_mem_stalls <= '0;
    end else begin
      if (fill_fire) begin
        perf_fills <= perf_fills + 32'd1;
      end
      if (mem_req_valid && !mem_req_ready) begin
        perf_mem_stalls <= perf_mem_stalls + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_cache_fill_unit.sv
// tb/tb_cache_fill_unit.sv - self-checking bench for cache_fill_unit
// Purpose: drives misses and memory responses, keeps scoreboards of expected
//          memory requests and fills, and checks order, latency and pending flags.
// Ports:   none (top-level bench).
module tb_cache_fill_unit;
  import cache_fill_pkg::*;

  localparam int AW  = CF_MSHR_ADDR_WIDTH;
  localparam int LAW = CF_LINE_ADDR_WIDTH;
  localparam int LW  = LINE_WIDTH;
  localparam int NS  = CF_MSHR_SIZE;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           miss_valid = 1'b0;
  logic [AW-1:0]  miss_id = '0;
  logic [LAW-1:0] miss_addr = '0;
  logic           miss_ready;
  logic           mem_req_valid;
  logic [LAW-1:0] mem_req_addr;
  logic [AW-1:0]  mem_req_tag;
  logic           mem_req_ready = 1'b0;
  logic           mem_rsp_valid = 1'b0;
  logic [AW-1:0]  mem_rsp_tag = '0;
  logic [LW-1:0]  mem_rsp_data = '0;
  logic           mem_rsp_ready;
  logic           fill_valid;
  logic [AW-1:0]  fill_id;
  logic [LW-1:0]  fill_data;
  logic           fill_ready = 1'b0;
  logic [NS-1:0]  pending;
  logic           idle;
`ifdef CACHE_FILL_PERF_EN
  logic [31:0]    perf_fills;
  logic [31:0]    perf_mem_stalls;
`endif

  int checks = 0;
  int errors = 0;

  miss_req_t     exp_req_q[$];
  miss_req_t     got_req_q[$];
  fill_rsp_t     exp_fill_q[$];
  fill_rsp_t     got_fill_q[$];
  logic [NS-1:0] exp_pending = '0;

  always #5 clk = ~clk;

  cache_fill_unit dut (
    .clk          (clk),
    .reset        (reset),
    .miss_valid   (miss_valid),
    .miss_id      (miss_id),
    .miss_addr    (miss_addr),
    .miss_ready   (miss_ready),
    .mem_req_valid(mem_req_valid),
    .mem_req_addr (mem_req_addr),
    .mem_req_tag  (mem_req_tag),
    .mem_req_ready(mem_req_ready),
    .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_tag  (mem_rsp_tag),
    .mem_rsp_data (mem_rsp_data),
    .mem_rsp_ready(mem_rsp_ready),
    .fill_valid   (fill_valid),
    .fill_id      (fill_id),
    .fill_data    (fill_data),
    .fill_ready   (fill_ready),
    .pending      (pending),
    .idle         (idle)
`ifdef CACHE_FILL_PERF_EN
    ,
    .perf_fills     (perf_fills),
    .perf_mem_stalls(perf_mem_stalls)
`endif
  );

  function automatic logic [LW-1:0] pat(input int k);
    return {16{32'hC0DE_0000 + 32'(k)}};
  endfunction

  // One clock: record handshakes that fire at the coming edge, then step to the next negedge.
  task automatic advance();
    miss_req_t r;
    fill_rsp_t f;
    if (miss_valid && miss_ready) begin
      r.addr = miss_addr; r.id = miss_id;
      exp_req_q.push_back(r);
    end
    if (mem_req_valid && mem_req_ready) begin
      r.addr = mem_req_addr; r.id = mem_req_tag;
      got_req_q.push_back(r);
    end
    if (mem_rsp_valid && mem_rsp_ready) begin
      f.id = mem_rsp_tag; f.data = mem_rsp_data;
      exp_fill_q.push_back(f);
    end
    if (fill_valid && fill_ready) begin
      f.id = fill_id; f.data = fill_data;
      got_fill_q.push_back(f);
      exp_pending[fill_id] = 1'b0;
    end
    if (miss_valid && miss_ready) exp_pending[miss_id] = 1'b1;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_miss(input int id, input logic [LAW-1:0] addr);
    int n = 0;
    miss_valid = 1'b1; miss_id = AW'(id); miss_addr = addr;
    while (!miss_ready && n < 50) begin advance(); n++; end
    if (!miss_ready) begin
      checks++; errors++;
      $display("FAIL miss_timeout: id %0d never accepted, miss_ready=%b required 1", id, miss_ready);
    end else begin
      advance();
    end
    miss_valid = 1'b0;
  endtask

  task automatic respond(input int tag, input logic [LW-1:0] data);
    int n = 0;
    mem_rsp_valid = 1'b1; mem_rsp_tag = AW'(tag); mem_rsp_data = data;
    while (!mem_rsp_ready && n < 50) begin advance(); n++; end
    if (!mem_rsp_ready) begin
      checks++; errors++;
      $display("FAIL rsp_timeout: tag %0d never accepted, mem_rsp_ready=%b required 1", tag, mem_rsp_ready);
    end else begin
      advance();
    end
    mem_rsp_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(idle && !fill_valid && !mem_req_valid) && n < 100) begin advance(); n++; end
    if (!idle) begin
      checks++; errors++;
      $display("FAIL idle_timeout: idle=%b required 1", idle);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    advance(); advance();
    reset = 1'b0;
    checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL rst_mem_req_valid: got %b required 0", mem_req_valid); end
    checks++; if (mem_rsp_ready !== 1'b1) begin errors++; $display("FAIL rst_mem_rsp_ready: got %b required 1", mem_rsp_ready); end
    checks++; if (fill_valid !== 1'b0) begin errors++; $display("FAIL rst_fill_valid: got %b required 0", fill_valid); end
    checks++; if (miss_ready !== 1'b1) begin errors++; $display("FAIL rst_miss_ready: got %b required 1", miss_ready); end
    checks++; if (pending !== '0) begin errors++; $display("FAIL rst_pending: got %h required 0", pending); end
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL rst_idle: got %b required 1", idle); end
  endtask

  task automatic test_single_miss();
    mem_req_ready = 1'b1; fill_ready = 1'b1;
    miss_valid = 1'b1; miss_id = AW'(3); miss_addr = LAW'(32'h100);
    advance();  // t0: miss fires
    miss_valid = 1'b0;
    checks++;
    if (mem_req_valid !== 1'b1 || mem_req_tag !== AW'(3) || mem_req_addr !== LAW'(32'h100)) begin
      errors++; $display("FAIL single_req_t1: got valid %b tag %0d addr %h required 1/3/100", mem_req_valid, mem_req_tag, mem_req_addr);
    end
    checks++; if (pending[3] !== 1'b1) begin errors++; $display("FAIL single_pending_t1: got %b required 1", pending[3]); end
    advance();  // t1: request issued
    checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL single_req_pop: got %b required 0", mem_req_valid); end
    advance(); advance(); advance();
    mem_rsp_valid = 1'b1; mem_rsp_tag = AW'(3); mem_rsp_data = {64{8'hAB}};
    advance();  // t5: response fires
    mem_rsp_valid = 1'b0;
    checks++;
    if (fill_valid !== 1'b1 || fill_id !== AW'(3) || fill_data !== {64{8'hAB}}) begin
      errors++; $display("FAIL single_fill_t6: got valid %b id %0d data[31:0] %h required 1/3/abababab", fill_valid, fill_id, fill_data[31:0]);
    end
    checks++; if (pending[3] !== 1'b1) begin errors++; $display("FAIL single_pending_t6: got %b required 1", pending[3]); end
    advance();  // t6: fill fires
    checks++; if (pending !== '0) begin errors++; $display("FAIL single_pending_t7: got %h required 0", pending); end
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL single_idle_t7: got %b required 1", idle); end
    while (got_req_q.size() > 0 || exp_req_q.size() > 0) begin
      miss_req_t g, e;
      g = '1; e = '0;
      if (got_req_q.size() > 0) g = got_req_q.pop_front();
      if (exp_req_q.size() > 0) e = exp_req_q.pop_front();
      checks++;
      if (g !== e) begin errors++; $display("FAIL single_req_sb: got tag %0d addr %h required tag %0d addr %h", g.id, g.addr, e.id, e.addr); end
    end
    while (got_fill_q.size() > 0 || exp_fill_q.size() > 0) begin
      fill_rsp_t g, e;
      g = '1; e = '0;
      if (got_fill_q.size() > 0) g = got_fill_q.pop_front();
      if (exp_fill_q.size() > 0) e = exp_fill_q.pop_front();
      checks++;
      if (g !== e) begin errors++; $display("FAIL single_fill_sb: got id %0d data[31:0] %h required id %0d data[31:0] %h", g.id, g.data[31:0], e.id, e.data[31:0]); end
    end
  endtask

  task automatic test_req_backpressure();
    mem_req_ready = 1'b0; fill_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      miss_valid = 1'b1; miss_id = AW'(i); miss_addr = LAW'(32'h200 + i);
      checks++;
      if (miss_ready !== (i < 4)) begin errors++; $display("FAIL reqbp_miss_ready[%0d]: got %b required %b", i, miss_ready, (i < 4)); end
      if (miss_ready) advance();
    end
    mem_req_ready = 1'b1;
    do_miss(4, LAW'(32'h204));
    for (int n = 0; n < 20 && mem_req_valid; n++) advance();
    for (int k = 0; k < 5; k++) begin
      miss_req_t g, e;
      g = '1; e = '0;
      if (got_req_q.size() > 0) g = got_req_q.pop_front();
      if (exp_req_q.size() > 0) e = exp_req_q.pop_front();
      checks++;
      if (g !== e || g.id !== AW'(k)) begin
        errors++; $display("FAIL reqbp_order[%0d]: got tag %0d addr %h required tag %0d addr %h", k, g.id, g.addr, k, e.addr);
      end
    end
    for (int k = 0; k < 5; k++) respond(k, pat(k));
    wait_idle();
    while (got_fill_q.size() > 0 || exp_fill_q.size() > 0) begin
      fill_rsp_t g, e;
      g = '1; e = '0;
      if (got_fill_q.size() > 0) g = got_fill_q.pop_front();
      if (exp_fill_q.size() > 0) e = exp_fill_q.pop_front();
      checks++;
      if (g !== e) begin errors++; $display("FAIL reqbp_fill_sb: got id %0d data[31:0] %h required id %0d data[31:0] %h", g.id, g.data[31:0], e.id, e.data[31:0]); end
    end
  endtask

  task automatic test_fill_backpressure();
    int order [3] = '{7, 5, 6};
    mem_req_ready = 1'b1; fill_ready = 1'b0;
    do_miss(5, LAW'(32'h305)); do_miss(6, LAW'(32'h306)); do_miss(7, LAW'(32'h307));
    respond(7, pat(17)); respond(5, pat(15));
    checks++; if (mem_rsp_ready !== 1'b0) begin errors++; $display("FAIL fillbp_rsp_ready: got %b required 0", mem_rsp_ready); end
    mem_rsp_valid = 1'b1; mem_rsp_tag = AW'(6); mem_rsp_data = pat(16);
    advance(); advance();
    checks++; if (mem_rsp_ready !== 1'b0 || fill_id !== AW'(7)) begin errors++; $display("FAIL fillbp_hold: got rsp_ready %b fill_id %0d required 0/7", mem_rsp_ready, fill_id); end
    fill_ready = 1'b1;
    respond(6, pat(16));
    wait_idle();
    for (int k = 0; k < 3; k++) begin
      fill_rsp_t g, e;
      g = '1; e = '0;
      if (got_fill_q.size() > 0) g = got_fill_q.pop_front();
      if (exp_fill_q.size() > 0) e = exp_fill_q.pop_front();
      checks++;
      if (g !== e || g.id !== AW'(order[k])) begin
        errors++; $display("FAIL fillbp_order[%0d]: got id %0d data[31:0] %h required id %0d data[31:0] %h", k, g.id, g.data[31:0], order[k], e.data[31:0]);
      end
    end
    got_req_q.delete(); exp_req_q.delete();
  endtask

  task automatic test_out_of_order();
    int order [3] = '{2, 0, 1};
    logic [2:0] exp_low [3] = '{3'b011, 3'b010, 3'b000};
    mem_req_ready = 1'b1; fill_ready = 1'b1;
    do_miss(0, LAW'(32'h400)); do_miss(1, LAW'(32'h401)); do_miss(2, LAW'(32'h402));
    for (int k = 0; k < 3; k++) begin
      respond(order[k], pat(40 + order[k]));
      advance();
      checks++;
      if (pending[2:0] !== exp_low[k] || pending !== exp_pending) begin
        errors++; $display("FAIL ooo_pending[%0d]: got %h required %h", k, pending, exp_pending);
      end
    end
    for (int k = 0; k < 3; k++) begin
      fill_rsp_t g, e;
      g = '1; e = '0;
      if (got_fill_q.size() > 0) g = got_fill_q.pop_front();
      if (exp_fill_q.size() > 0) e = exp_fill_q.pop_front();
      checks++;
      if (g !== e || g.id !== AW'(order[k])) begin
        errors++; $display("FAIL ooo_order[%0d]: got id %0d data[31:0] %h required id %0d data[31:0] %h", k, g.id, g.data[31:0], order[k], e.data[31:0]);
      end
    end
    got_req_q.delete(); exp_req_q.delete();
  endtask

  task automatic test_reset_mid();
    mem_req_ready = 1'b0; fill_ready = 1'b0;
    do_miss(8, LAW'(32'h508)); do_miss(9, LAW'(32'h509)); do_miss(10, LAW'(32'h50A));
    respond(8, pat(58)); respond(9, pat(59));
    checks++; if (mem_req_valid !== 1'b1 || fill_valid !== 1'b1) begin errors++; $display("FAIL rstmid_loaded: got req %b fill %b required 1/1", mem_req_valid, fill_valid); end
    reset = 1'b1;
    advance();
    reset = 1'b0;
    checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL rstmid_req_valid: got %b required 0", mem_req_valid); end
    checks++; if (fill_valid !== 1'b0) begin errors++; $display("FAIL rstmid_fill_valid: got %b required 0", fill_valid); end
    checks++; if (pending !== '0) begin errors++; $display("FAIL rstmid_pending: got %h required 0", pending); end
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL rstmid_idle: got %b required 1", idle); end
    checks++; if (miss_ready !== 1'b1 || mem_rsp_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready: got miss %b rsp %b required 1/1", miss_ready, mem_rsp_ready); end
    exp_req_q.delete(); got_req_q.delete(); exp_fill_q.delete(); got_fill_q.delete();
    exp_pending = '0;
  endtask

`ifdef CACHE_FILL_PERF_EN
  task automatic test_perf();
    reset = 1'b1; advance(); reset = 1'b0;
    checks++; if (perf_fills !== 32'd0 || perf_mem_stalls !== 32'd0) begin errors++; $display("FAIL perf_reset: got %0d/%0d required 0/0", perf_fills, perf_mem_stalls); end
    mem_req_ready = 1'b0; fill_ready = 1'b1;
    do_miss(0, LAW'(32'h600));
    repeat (7) advance();
    mem_req_ready = 1'b1;
    advance();
    for (int k = 1; k < 4; k++) do_miss(k, LAW'(32'h600 + k));
    for (int k = 0; k < 4; k++) respond(k, pat(60 + k));
    wait_idle();
    checks++; if (perf_fills !== 32'd4) begin errors++; $display("FAIL perf_fills: got %0d required 4", perf_fills); end
    checks++; if (perf_mem_stalls !== 32'd7) begin errors++; $display("FAIL perf_mem_stalls: got %0d required 7", perf_mem_stalls); end
  endtask
`endif

  initial begin
    @(negedge clk);
    test_reset();
    test_single_miss();
    test_req_backpressure();
    test_fill_backpressure();
    test_out_of_order();
    test_reset_mid();
`ifdef CACHE_FILL_PERF_EN
    test_perf();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
